// File: rtl/tetris_game_ctrl.sv
// rtl/tetris_game_ctrl.sv - Tetris sequencing controller: gravity, input arbitration, command channel, score
module tetris_game_ctrl #(
    parameter int GRAVITY_TICKS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        tick,
    input  logic        rotate,
    input  logic        rotate_direction,
    input  logic        left,
    input  logic        right,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic        rsp_ok,
    input  logic [2:0]  rows_cleared,
    output logic        game_over,
    output logic [15:0] lines,
    output logic [19:0] score,
    output logic [2:0]  state
);
    localparam int CW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;

    localparam logic [2:0] OP_SPAWN = 3'd0, OP_LEFT = 3'd1, OP_RIGHT = 3'd2, OP_ROT_CW = 3'd3,
                           OP_ROT_CCW = 3'd4, OP_DOWN = 3'd5, OP_LOCK = 3'd6, OP_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0, S_SPAWN = 3'd1, S_READY = 3'd2, S_ISSUE = 3'd3,
        S_WAIT  = 3'd4, S_LOCK  = 3'd5, S_CLEAR = 3'd6, S_OVER  = 3'd7
    } state_t;

    state_t          st;
    logic            pend_rot, pend_left, pend_right, pend_grav, rot_cw;
    logic [CW-1:0]   gcnt;

    logic            accept_req, set_rot, set_left, set_right;
    logic            grav_run, grav_wrap, pick;
    logic            take_rot, take_left, take_right, take_grav;
    logic [2:0]      rows_eff;
    logic [10:0]     score_add;
    logic [20:0]     score_sum;
    logic [16:0]     lines_sum;

    assign state = st;

    assign accept_req = run && (st != S_IDLE) && (st != S_OVER);
    assign set_rot    = accept_req && rotate;
    assign set_left   = accept_req && left && !right;
    assign set_right  = accept_req && right && !left;

    assign grav_run  = run && (st == S_READY || st == S_ISSUE || st == S_WAIT);
    assign grav_wrap = grav_run && tick && (gcnt == CW'(GRAVITY_TICKS - 1));

    // Fixed arbitration: rotate > left > right > gravity.
    assign pick       = run && (st == S_READY);
    assign take_rot   = pick && pend_rot;
    assign take_left  = pick && !pend_rot && pend_left;
    assign take_right = pick && !pend_rot && !pend_left && pend_right;
    assign take_grav  = pick && !pend_rot && !pend_left && !pend_right && pend_grav;

    always_comb begin
        rows_eff = (rows_cleared > 3'd4) ? 3'd4 : rows_cleared;
        case (rows_eff)
            3'd1:    score_add = 11'd40;
            3'd2:    score_add = 11'd100;
            3'd3:    score_add = 11'd300;
            3'd4:    score_add = 11'd1200;
            default: score_add = 11'd0;
        endcase
        score_sum = {1'b0, score} + {10'd0, score_add};
        lines_sum = {1'b0, lines} + {14'd0, rows_eff};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            cmd_valid  <= 1'b0;
            cmd_op     <= OP_SPAWN;
            game_over  <= 1'b0;
            lines      <= '0;
            score      <= '0;
            pend_rot   <= 1'b0;
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            pend_grav  <= 1'b0;
            rot_cw     <= 1'b0;
            gcnt       <= '0;
        end else begin
            // A pulse landing on the consuming cycle re-arms its flag.
            pend_rot   <= (pend_rot   && !take_rot)   || set_rot;
            pend_left  <= (pend_left  && !take_left)  || set_left;
            pend_right <= (pend_right && !take_right) || set_right;
            pend_grav  <= (pend_grav  && !take_grav)  || grav_wrap;
            if (set_rot)
                rot_cw <= rotate_direction;
            if (grav_run && tick)
                gcnt <= grav_wrap ? '0 : gcnt + CW'(1);

            case (st)
                S_IDLE: if (run) st <= S_SPAWN;
                S_SPAWN: if (run) begin
                    pend_rot   <= 1'b0;
                    pend_left  <= 1'b0;
                    pend_right <= 1'b0;
                    pend_grav  <= 1'b0;
                    gcnt       <= '0;
                    cmd_valid  <= 1'b1;
                    cmd_op     <= OP_SPAWN;
                    st         <= S_ISSUE;
                end
                S_READY: if (take_rot || take_left || take_right || take_grav) begin
                    cmd_valid <= 1'b1;
                    st        <= S_ISSUE;
                    if (take_rot)       cmd_op <= rot_cw ? OP_ROT_CW : OP_ROT_CCW;
                    else if (take_left) cmd_op <= OP_LEFT;
                    else if (take_right) cmd_op <= OP_RIGHT;
                    else                cmd_op <= OP_DOWN;
                end
                S_ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    st        <= S_WAIT;
                end
                S_WAIT: if (rsp_valid) begin
                    case (cmd_op)
                        OP_SPAWN: begin
                            st        <= rsp_ok ? S_READY : S_OVER;
                            game_over <= !rsp_ok;
                        end
                        OP_DOWN:  st <= rsp_ok ? S_READY : S_LOCK;
                        OP_LOCK:  st <= S_CLEAR;
                        OP_CLEAR: begin
                            lines <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                            score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                            st    <= S_SPAWN;
                        end
                        default:  st <= S_READY;
                    endcase
                end
                S_LOCK: if (run) begin
                    cmd_valid <= 1'b1;
                    cmd_op    <= OP_LOCK;
                    st        <= S_ISSUE;
                end
                S_CLEAR: if (run) begin
                    cmd_valid <= 1'b1;
                    cmd_op    <= OP_CLEAR;
                    st        <= S_ISSUE;
                end
                default: st <= S_OVER;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb/tb_tetris_game_ctrl.sv - directed-vector bench for tetris_game_ctrl
module tb_tetris_game_ctrl;
    localparam int G = 16;

    logic        clk = 1'b0;
    logic        reset, run, tick_drv, auto_tick, rotate, rotate_direction, left, right;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ok, game_over;
    logic [2:0]  cmd_op, rows_cleared, state;
    logic [15:0] lines;
    logic [19:0] score;
    logic        tick;

    int vectors = 0;
    int miscompares = 0;

    assign tick = tick_drv | auto_tick;

    tetris_game_ctrl #(.GRAVITY_TICKS(G)) dut (
        .clk(clk), .reset(reset), .run(run), .tick(tick), .rotate(rotate),
        .rotate_direction(rotate_direction), .left(left), .right(right),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rows_cleared(rows_cleared),
        .game_over(game_over), .lines(lines), .score(score), .state(state)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input string tag, input logic [2:0] op);
        int n = 0;
        while (!cmd_valid && n < 200) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(cmd_valid), 1);
        check({tag, "_op"}, 32'(cmd_op), 32'(op));
    endtask

    task automatic handshake(input string tag, input logic [2:0] op, input logic ok, input logic [2:0] rows);
        wait_cmd(tag, op);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_ok = ok;
        rows_cleared = rows;
        step();
        rsp_valid = 1'b0;
        rsp_ok = 1'b0;
        rows_cleared = 3'd0;
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (cmd_valid) seen++;
            step();
        end
        check(tag, 32'(seen), 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_drv = 1'b1;
            step();
            tick_drv = 1'b0;
            step();
        end
    endtask

    // Gravity DOWN refused, then LOCK, CLEAR, and the following SPAWN.
    task automatic round(input logic [2:0] rows, input logic spawn_ok);
        handshake("rnd_down", 3'd5, 1'b0, 3'd0);
        handshake("rnd_lock", 3'd6, 1'b1, 3'd0);
        handshake("rnd_clear", 3'd7, 1'b1, rows);
        handshake("rnd_spawn", 3'd0, spawn_ok, 3'd0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; tick_drv = 1'b0; auto_tick = 1'b0;
        rotate = 1'b0; rotate_direction = 1'b0; left = 1'b0; right = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ok = 1'b0; rows_cleared = 3'd0;
        step(); step();
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_op", 32'(cmd_op), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_lines", 32'(lines), 0);
        check("rst_score", 32'(score), 0);
        check("rst_state", 32'(state), 0);
        reset = 1'b0;
        step();

        // run rising: SPAWN state next cycle, SPAWN offered the cycle after
        run = 1'b1;
        step();
        check("spawn_state", 32'(state), 1);
        step();
        check("spawn_valid", 32'(cmd_valid), 1);
        check("spawn_op", 32'(cmd_op), 0);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("accept_drop", 32'(cmd_valid), 0);
        check("accept_wait", 32'(state), 4);
        rsp_valid = 1'b1; rsp_ok = 1'b1;
        step();
        rsp_valid = 1'b0; rsp_ok = 1'b0;
        check("spawn_ready", 32'(state), 2);

        // G-1 ticks: no command; G-th tick: one DOWN two cycles later
        ticks(G - 1);
        quiet("grav_early", 4);
        tick_drv = 1'b1;
        step();
        tick_drv = 1'b0;
        step();
        check("grav_valid", 32'(cmd_valid), 1);
        check("grav_op", 32'(cmd_op), 5);
        handshake("grav", 3'd5, 1'b1, 3'd0);
        quiet("grav_once", 10);

        // rotate CCW + left + gravity wrap in one cycle
        ticks(G - 1);
        rotate = 1'b1; rotate_direction = 1'b0; left = 1'b1; tick_drv = 1'b1;
        step();
        rotate = 1'b0; left = 1'b0; tick_drv = 1'b0;
        handshake("prio_rot", 3'd4, 1'b1, 3'd0);
        handshake("prio_left", 3'd1, 1'b1, 3'd0);
        handshake("prio_down", 3'd5, 1'b1, 3'd0);
        quiet("prio_done", 4);
        left = 1'b1; right = 1'b1;
        step();
        left = 1'b0; right = 1'b0;
        quiet("lr_discard", 8);

        // scoring per row count, rows>4 treated as 4, then saturation
        auto_tick = 1'b1;
        round(3'd4, 1'b1);
        check("r4_lines", 32'(lines), 4);
        check("r4_score", 32'(score), 1200);
        round(3'd1, 1'b1);
        check("r1_lines", 32'(lines), 5);
        check("r1_score", 32'(score), 1240);
        round(3'd2, 1'b1);
        check("r2_lines", 32'(lines), 7);
        check("r2_score", 32'(score), 1340);
        round(3'd3, 1'b1);
        check("r3_lines", 32'(lines), 10);
        check("r3_score", 32'(score), 1640);
        round(3'd0, 1'b1);
        check("r0_lines", 32'(lines), 10);
        check("r0_score", 32'(score), 1640);
        for (int k = 1; k <= 875; k++) begin
            round((k % 2 == 1) ? 3'd7 : 3'd4, (k == 875) ? 1'b0 : 1'b1);
            if (k == 872) begin
                check("presat_score", 32'(score), 1048040);
                check("presat_lines", 32'(lines), 3498);
            end
            if (k == 873)
                check("sat_score", 32'(score), 1048575);
        end
        check("sat_hold", 32'(score), 1048575);
        check("sat_lines", 32'(lines), 3510);
        check("over_flag", 32'(game_over), 1);
        check("over_state", 32'(state), 7);

        // game over: pulses and ticks issue nothing
        left = 1'b1; rotate = 1'b1;
        step();
        left = 1'b0; rotate = 1'b0;
        quiet("over_quiet", 20);
        check("over_stay", 32'(state), 7);
        auto_tick = 1'b0;
        run = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_valid", 32'(cmd_valid), 0);
        check("rst2_over", 32'(game_over), 0);
        check("rst2_lines", 32'(lines), 0);
        check("rst2_score", 32'(score), 0);
        check("rst2_state", 32'(state), 0);

        // backpressure: offer held stable, rotate repeats merge, last direction wins
        run = 1'b1;
        handshake("spawn2", 3'd0, 1'b1, 3'd0);
        left = 1'b1;
        step();
        left = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(cmd_valid), 1);
            check("stall_op", 32'(cmd_op), 1);
            rotate = (i == 2 || i == 3);
            rotate_direction = (i == 2);
            step();
        end
        rotate = 1'b0;
        handshake("stall_left", 3'd1, 1'b0, 3'd0);
        handshake("merge_rot", 3'd4, 1'b1, 3'd0);
        quiet("merge_once", 8);

        // pause mid-wait: transaction completes, then everything frozen
        right = 1'b1;
        step();
        right = 1'b0;
        wait_cmd("pause_right", 3'd2);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        run = 1'b0;
        step(); step(); step();
        rsp_valid = 1'b1; rsp_ok = 1'b1;
        step();
        rsp_valid = 1'b0; rsp_ok = 1'b0;
        check("pause_ready", 32'(state), 2);
        left = 1'b1;
        step();
        left = 1'b0;
        ticks(20);
        quiet("pause_quiet", 6);
        run = 1'b1;
        quiet("resume_quiet", 5);
        ticks(G - 1);
        quiet("resume_frozen", 4);
        tick_drv = 1'b1;
        step();
        tick_drv = 1'b0;
        handshake("resume_down", 3'd5, 1'b1, 3'd0);

        // reset during WAIT abandons the command; late response ignored
        left = 1'b1;
        step();
        left = 1'b0;
        wait_cmd("rstw_left", 3'd1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("rstw_wait", 32'(state), 4);
        run = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_state", 32'(state), 0);
        check("rstw_valid", 32'(cmd_valid), 0);
        rsp_valid = 1'b1; rsp_ok = 1'b1;
        step();
        rsp_valid = 1'b0; rsp_ok = 1'b0;
        check("late_state", 32'(state), 0);
        check("late_valid", 32'(cmd_valid), 0);
        check("late_over", 32'(game_over), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tetris_game_ctrl.md
# tetris_game_ctrl

Sequencing controller for the Tetris board datapath. It turns the 100 Hz game tick and the player input pulses into a serialized stream of piece commands (spawn, move, rotate, drop, lock, clear) over a valid/ready command channel with a separate response pulse. It owns gravity timing, input arbitration, game-over detection and the line/score counters. It sits between the rate divider / input conditioning and the board-update datapath.

## Interface
- `GRAVITY_TICKS`, default 60: tick pulses per automatic DOWN command.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `run` in 1: 1 = game runs, 0 = paused.
- `tick` in 1: one-cycle game-tick pulse from the rate divider.
- `rotate` in 1: one-cycle rotate request pulse.
- `rotate_direction` in 1: 1 = CW, 0 = CCW; sampled with `rotate`.
- `left` in 1: one-cycle move-left request pulse.
- `right` in 1: one-cycle move-right request pulse.
- `cmd_valid` out 1: command offered.
- `cmd_op` out 3: 0 SPAWN, 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 DOWN, 6 LOCK, 7 CLEAR.
- `cmd_ready` in 1: datapath accepts command.
- `rsp_valid` in 1: one-cycle completion pulse from datapath.
- `rsp_ok` in 1: 1 = move/spawn legal, 0 = collision; ignored for LOCK/CLEAR.
- `rows_cleared` in 3: full rows removed, valid with CLEAR response; values >4 treated as 4.
- `game_over` out 1: latched game-over flag.
- `lines` out 16: total cleared rows, saturating at 65535.
- `score` out 20: rows 1/2/3/4 add 40/100/300/1200, saturating at 2^20-1.
- `state` out 3: FSM state code, for debug.

## Operation
- States and codes: IDLE 0, SPAWN 1, READY 2, ISSUE 3, WAIT 4, LOCK 5, CLEAR 6, OVER 7.
- IDLE: leaves for SPAWN when `run` is 1.
- SPAWN: clears all pending flags and the gravity counter, then issues SPAWN.
  - `rsp_ok`=1 goes to READY.
  - `rsp_ok`=0 goes to OVER.
- READY: with `run`=1, picks the highest-priority pending flag, clears it, and goes to ISSUE.
  - Priority: rotate > left > right > gravity.
  - Nothing pending, or `run`=0: stays in READY.
- ISSUE: holds `cmd_valid`=1 with a stable `cmd_op` until `cmd_ready`=1, then goes to WAIT.
- WAIT: waits for `rsp_valid`.
  - LEFT/RIGHT/ROT responses return to READY, whatever `rsp_ok` is.
  - DOWN with `rsp_ok`=1 returns to READY; DOWN with `rsp_ok`=0 goes to LOCK.
- LOCK: issues LOCK; the response goes to CLEAR.
- CLEAR: issues CLEAR. On the response, `lines` and `score` update, then the FSM goes to SPAWN.
- OVER: `game_over`=1, no commands issued; only `reset` exits.
- Pending flags: rotate (plus captured direction), left, right, gravity. Each is set by its pulse when `run`=1 and state is not IDLE/OVER.
  - A repeat pulse while the flag is already set merges: one command.
  - A new `rotate` overwrites the stored direction.
  - `left` and `right` in the same cycle: both discarded.
- Gravity counter: 0..`GRAVITY_TICKS`-1.
  - Increments on `tick` when `run`=1 and state is READY/ISSUE/WAIT.
  - On `tick` at `GRAVITY_TICKS`-1: wraps to 0 and sets the gravity flag.
- Pause (`run`=0): an outstanding ISSUE/WAIT transaction completes. `tick` and request pulses are ignored, and nothing new is issued.

## Timing
- Reset values:
  - Outputs: `cmd_valid`=0, `cmd_op`=0, `game_over`=0, `lines`=0, `score`=0, `state`=IDLE.
  - Internal: all pending flags 0, gravity counter 0.
- Reset has priority over every event, including a mid-transaction handshake. The datapath must tolerate an abandoned command.
- All outputs are registered.
- Request pulse at cycle n with FSM in READY: `cmd_valid`=1 at n+2 (flag set at n+1, decision at n+1).
- `run` rising at cycle n in IDLE: SPAWN is offered at n+2.
- `cmd_valid`=1 and `cmd_ready`=1 in the same cycle is the accepting cycle. `cmd_valid` drops on the next cycle.
- `rsp_valid` is legal from the cycle after acceptance. A `rsp_valid` outside WAIT is ignored.
- `lines` and `score` update in the cycle after the CLEAR response.
- A pulse arriving in the same cycle its own flag is being consumed re-sets the flag, so one further command is issued.

## Test plan
- Reset, `run`=1, datapath always ready with `rsp_ok`=1 one cycle after acceptance -> SPAWN at cycle 2, then READY. After 60 ticks, exactly one DOWN is issued.
- Same-cycle `rotate` (dir=0), `left` and gravity flag -> ROT_CCW, then LEFT, then DOWN, serialized by handshakes. `left`+`right` in the same cycle -> no move command.
- DOWN answered `rsp_ok`=0, CLEAR answered `rows_cleared`=4 -> LOCK, CLEAR, SPAWN sequence; `lines`=4, `score`=1200. Repeated to saturation, `score` holds at 1048575.
- SPAWN answered `rsp_ok`=0 -> `game_over`=1, state 7. Further pulses and ticks issue no commands. `reset` returns all outputs to 0.
- `cmd_ready` held low 10 cycles -> `cmd_valid`/`cmd_op` stable throughout. Dropping `run` mid-wait completes the transaction, then no commands are issued and the gravity counter is frozen.
- `reset` asserted during WAIT -> next cycle state IDLE, `cmd_valid`=0; a late `rsp_valid` is ignored.
